// File: rtl/seg_counter_mux_pkg.sv
// rtl/seg_counter_mux_pkg.sv - shared glyph constants and BCD-to-7-segment decoder
package seg_pkg;

    localparam int DIGIT_W = 4;

    // bit0..6 = a..g, bit7 = dp (always off)
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [7:0] bcd_to_seg(input logic [DIGIT_W-1:0] nibble);
        logic [7:0] glyph;
        case (nibble)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg_counter_mux_debounce.sv
// rtl/seg_counter_mux_debounce.sv - 2-FF synchroniser, stable-sample debouncer and press pulse
module btn_debounce
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] stable_cnt;

    // The edge that would take the counter to DEBOUNCE_CYCLES accepts the new level instead
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1      <= 1'b0;
            sync_2      <= 1'b0;
            stable_cnt  <= '0;
            btn_level   <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            sync_1      <= btn_raw;
            sync_2      <= sync_1;
            press_pulse <= 1'b0;
            if (sync_2 == btn_level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                stable_cnt  <= '0;
                btn_level   <= sync_2;
                press_pulse <= sync_2;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/seg_counter_mux.sv
// rtl/seg_counter_mux.sv - debounced BCD up/down counter on a multiplexed display (option: SEG_LEADING_ZERO_BLANK_EN)
module seg_counter_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_DIV        = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          btn_inc,
    input  logic                          btn_dec,
    output logic [7:0]                    seg,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic [DIGIT_W*NUM_DIGITS-1:0] count_bcd,
    output logic                          wrap
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(SCAN_DIV - 1);

    logic inc_pulse;
    logic dec_pulse;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_debounce (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_inc),
        .btn_level   (),
        .press_pulse (inc_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec_debounce (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_dec),
        .btn_level   (),
        .press_pulse (dec_pulse)
    );

    logic                          inc_only;
    logic                          dec_only;
    logic                          ripple;
    logic                          roll;
    logic [DIGIT_W-1:0]            digit;
    logic [DIGIT_W*NUM_DIGITS-1:0] count_next;

    assign inc_only = inc_pulse & ~dec_pulse;
    assign dec_only = dec_pulse & ~inc_pulse;

    // ripple is the carry (inc) or borrow (dec) entering each digit; out of the top digit it is a wrap
    always_comb begin
        count_next = count_bcd;
        ripple     = 1'b1;
        digit      = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            digit = count_bcd[k*DIGIT_W +: DIGIT_W];
            if (ripple && inc_only) begin
                if (digit == 4'd9) begin
                    count_next[k*DIGIT_W +: DIGIT_W] = 4'd0;
                end else begin
                    count_next[k*DIGIT_W +: DIGIT_W] = digit + 4'd1;
                    ripple = 1'b0;
                end
            end else if (ripple && dec_only) begin
                if (digit == 4'd0) begin
                    count_next[k*DIGIT_W +: DIGIT_W] = 4'd9;
                end else begin
                    count_next[k*DIGIT_W +: DIGIT_W] = digit - 4'd1;
                    ripple = 1'b0;
                end
            end
        end
        roll = ripple & (inc_only | dec_only);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_bcd <= '0;
            wrap      <= 1'b0;
        end else begin
            count_bcd <= count_next;
            wrap      <= roll;
        end
    end

    logic [PRE_W-1:0]      prescale;
    logic [IDX_W-1:0]      scan_idx;
    logic [IDX_W-1:0]      scan_next;
    logic [DIGIT_W-1:0]    shown_digit;
    logic                  shown_blank;
    logic [NUM_DIGITS-1:0] sel_next;
    logic [7:0]            seg_next;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;

    // lead_zero[k]: digit k and every digit above it are zero
    always_comb begin : leading_zero_scan
        logic all_zero;
        all_zero  = 1'b1;
        lead_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero     = all_zero & (count_bcd[k*DIGIT_W +: DIGIT_W] == 4'd0);
            lead_zero[k] = all_zero;
        end
    end
`endif

    // digit_sel and seg are both derived from scan_next so they update on the same edge
    always_comb begin
        scan_next = scan_idx;
        if (prescale == LAST_PRE) begin
            scan_next = (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
        end
        shown_digit = '0;
        shown_blank = 1'b0;
        sel_next    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scan_next == IDX_W'(k)) begin
                sel_next[k] = 1'b1;
                shown_digit = count_bcd[k*DIGIT_W +: DIGIT_W];
`ifdef SEG_LEADING_ZERO_BLANK_EN
                shown_blank = (k != 0) && lead_zero[k];
`endif
            end
        end
        seg_next = shown_blank ? SEG_BLANK : bcd_to_seg(shown_digit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale  <= '0;
            scan_idx  <= '0;
            digit_sel <= NUM_DIGITS'(1);
            seg       <= SEG_0;
        end else begin
            prescale  <= (prescale == LAST_PRE) ? '0 : prescale + PRE_W'(1);
            scan_idx  <= scan_next;
            digit_sel <= sel_next;
            seg       <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_counter_mux.sv
// tb/tb_seg_counter_mux.sv - directed scoreboard bench for seg_counter_mux (2 digits, debounce 4, scan 2)
module tb_seg_counter_mux;

    localparam int ND = 2;
    localparam int DB = 4;
    localparam int SD = 2;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          btn_inc = 1'b0;
    logic          btn_dec = 1'b0;
    logic [7:0]    seg;
    logic [ND-1:0] digit_sel;
    logic [4*ND-1:0] count_bcd;
    logic          wrap;

    int         n_checks = 0;
    int         n_errors = 0;
    int         model    = 0;
    logic [8:0] exp_q[$];
    logic [7:0] prev_count = '0;

    seg_counter_mux #(
        .NUM_DIGITS      (ND),
        .DEBOUNCE_CYCLES (DB),
        .SCAN_DIV        (SD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .seg       (seg),
        .digit_sel (digit_sel),
        .count_bcd (count_bcd),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] glyph(input int d);
        case (d)
            0: return 8'h3F;
            1: return 8'h06;
            2: return 8'h5B;
            3: return 8'h4F;
            4: return 8'h66;
            5: return 8'h6D;
            6: return 8'h7D;
            7: return 8'h07;
            8: return 8'h7F;
            9: return 8'h6F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    task automatic expect_step(input int delta);
        int nxt;
        logic w;
        nxt = model + delta;
        w   = 1'b0;
        if (nxt > 99) begin nxt -= 100; w = 1'b1; end
        if (nxt < 0)  begin nxt += 100; w = 1'b1; end
        model = nxt;
        exp_q.push_back({w, to_bcd(nxt)});
    endtask

    task automatic press(input logic do_inc, input logic do_dec, input int high, input int low);
        @(negedge clk);
        btn_inc = do_inc;
        btn_dec = do_dec;
        repeat (high) @(negedge clk);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        repeat (low) @(negedge clk);
    endtask

    task automatic check_scan(input string tag);
        logic [7:0] eu;
        logic [7:0] et;
        eu = glyph(model % 10);
        et = glyph(model / 10);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (model < 10) et = 8'h00;
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (digit_sel === 2'b01) check({tag, "_units"}, seg, eu);
            else                     check({tag, "_tens"}, {digit_sel, seg}, {2'b10, et});
        end
    endtask

    // Scoreboard: every count change must match the next queued step, including its wrap flag
    always @(negedge clk) begin : monitor
        logic [8:0] e;
        if (rst) begin
            prev_count = '0;
        end else if (count_bcd !== prev_count) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = 9'h1FF;
            check("count_step", count_bcd, e[7:0]);
            check("wrap_step", wrap, e[8]);
            prev_count = count_bcd;
        end else begin
            check("wrap_idle", wrap, 1'b0);
        end
    end

    initial begin
        int guard;

        repeat (3) @(negedge clk);
        check("rst_count", count_bcd, 8'h00);
        check("rst_wrap", wrap, 1'b0);
        check("rst_sel", digit_sel, 2'b01);
        check("rst_seg", seg, 8'h3F);
        rst = 1'b0;

        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("idle_sel", digit_sel, ((k / 2) % 2 != 0) ? 2'b10 : 2'b01);
            check("idle_seg", seg, 8'h3F);
            check("idle_count", count_bcd, 8'h00);
        end

        expect_step(1);
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (6) @(negedge clk);
        check("lat_before", count_bcd, 8'h00);
        @(negedge clk);
        check("lat_at7", count_bcd, 8'h01);
        repeat (3) @(negedge clk);
        btn_inc = 1'b0;
        repeat (8) @(negedge clk);
        check("hold_one_count", count_bcd, 8'h01);

        for (int i = 0; i < 11; i++) begin
            expect_step(1);
            press(1'b1, 1'b0, 10, 8);
        end
        check("count_12", count_bcd, 8'h12);
        check_scan("scan12");

        repeat (5) begin
            @(negedge clk);
            btn_inc = 1'b1;
            repeat (3) @(negedge clk);
            btn_inc = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check("glitch_ignored", count_bcd, 8'h12);
        expect_step(1);
        press(1'b1, 1'b0, 10, 8);
        check("after_glitch", count_bcd, 8'h13);

        check("queue_empty_pre_rst", exp_q.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        model = 0;
        check("rst_clear", count_bcd, 8'h00);

        expect_step(-1);
        press(1'b0, 1'b1, 10, 8);
        check("underflow", count_bcd, 8'h99);
        check_scan("scan99");
        expect_step(1);
        press(1'b1, 1'b0, 10, 8);
        check("overflow", count_bcd, 8'h00);

        press(1'b1, 1'b1, 10, 8);
        check("both_hold", count_bcd, 8'h00);

        expect_step(1);
        expect_step(-1);
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (5) @(negedge clk);
        btn_dec = 1'b1;
        repeat (5) @(negedge clk);
        btn_inc = 1'b0;
        repeat (5) @(negedge clk);
        btn_dec = 1'b0;
        repeat (10) @(negedge clk);
        check("offset_net_zero", count_bcd, 8'h00);
        check("queue_empty_offset", exp_q.size(), 0);

        expect_step(1);
        press(1'b1, 1'b0, 10, 8);
        check("pre_async_count", count_bcd, 8'h01);
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (2) @(negedge clk);
        guard = 0;
        while (digit_sel !== 2'b10 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("sel_before_async", digit_sel, 2'b10);
        #2 rst = 1'b1;
        #1;
        check("async_count", count_bcd, 8'h00);
        check("async_sel", digit_sel, 2'b01);
        check("async_seg", seg, 8'h3F);
        check("async_wrap", wrap, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        model = 0;
        expect_step(1);
        repeat (6) @(negedge clk);
        check("held_rel_before", count_bcd, 8'h00);
        @(negedge clk);
        check("held_rel_at7", count_bcd, 8'h01);
        repeat (3) @(negedge clk);
        btn_inc = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            expect_step(1);
            press(1'b1, 1'b0, 10, 8);
        end
        check("count_05", count_bcd, 8'h05);
        check_scan("scan05");

        check("queue_empty_end", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
